// File: rtl/reg_writeback.sv
// Write-back stage: buffers ALU/memory results in a small FIFO and issues one register write per cycle.
// Optional WB_BYPASS_EN adds a combinational forwarding port that looks up queued or staged data.
module reg_writeback #(
    parameter int DEPTH = 2,
    parameter int DW    = 4,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [AW-1:0]     in_wr,
    input  logic [DW-1:0]     in_data,
    input  logic              in_overflow,
    input  logic              rf_hold,
    input  logic              flush,
    output logic              RegWrite,
    output logic [AW-1:0]     Wr,
    output logic [DW-1:0]     Write_data,
    output logic [2**AW-1:0]  busy,
    output logic              ovf_sticky,
`ifdef WB_BYPASS_EN
    output logic [7:0]        drop_cnt,
    input  logic [AW-1:0]     byp_addr,
    output logic              byp_hit,
    output logic [DW-1:0]     byp_data
`else
    output logic [7:0]        drop_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

    logic [AW-1:0] memAddr_q [DEPTH];
    logic [DW-1:0] memData_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          regWrite_q, regWrite_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [DW-1:0] writeData_q, writeData_d;
    logic          ovfSticky_q, ovfSticky_d;
    logic [7:0]    dropCnt_q, dropCnt_d;

    logic full, empty, accept, doPush, doPop;
    logic [2**AW-1:0] busyV;

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign in_ready = !full && rst && !flush;
    assign accept   = in_valid && in_ready;
    assign doPush   = accept && !in_overflow && in_we && (in_wr != '0);
    assign doPop    = !empty && !rf_hold && !flush;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        regWrite_d  = 1'b0;
        wr_d        = wr_q;
        writeData_d = writeData_q;
        ovfSticky_d = ovfSticky_q;
        dropCnt_d   = dropCnt_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (doPop) begin
                regWrite_d  = 1'b1;
                wr_d        = memAddr_q[head_q];
                writeData_d = memData_q[head_q];
                head_d      = head_q + PW'(1);
            end
            if (doPush) begin
                tail_d = tail_q + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
            // Overflow drops are counted only when the handshake actually completes.
            if (accept && in_overflow) begin
                ovfSticky_d = 1'b1;
                if (dropCnt_q != 8'hFF) begin
                    dropCnt_d = dropCnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            regWrite_q  <= 1'b0;
            wr_q        <= '0;
            writeData_q <= '0;
            ovfSticky_q <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            regWrite_q  <= regWrite_d;
            wr_q        <= wr_d;
            writeData_q <= writeData_d;
            ovfSticky_q <= ovfSticky_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            memAddr_q[tail_q] <= in_wr;
            memData_q[tail_q] <= in_data;
        end
    end

    always_comb begin
        busyV = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count_q)) begin
                busyV[memAddr_q[head_q + PW'(i)]] = 1'b1;
            end
        end
        if (regWrite_q) begin
            busyV[wr_q] = 1'b1;
        end
        busyV[0] = 1'b0;
    end

    assign busy       = busyV;
    assign RegWrite   = regWrite_q;
    assign Wr         = wr_q;
    assign Write_data = writeData_q;
    assign ovf_sticky = ovfSticky_q;
    assign drop_cnt   = dropCnt_q;

`ifdef WB_BYPASS_EN
    logic          bypHit;
    logic [DW-1:0] bypData;

    // Scan oldest to youngest so the youngest match overrides; the staged entry is oldest of all.
    always_comb begin
        bypHit  = 1'b0;
        bypData = '0;
        if (byp_addr != '0) begin
            if (regWrite_q && (wr_q == byp_addr)) begin
                bypHit  = 1'b1;
                bypData = writeData_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((i < int'(count_q)) && (memAddr_q[head_q + PW'(i)] == byp_addr)) begin
                    bypHit  = 1'b1;
                    bypData = memData_q[head_q + PW'(i)];
                end
            end
        end
    end

    assign byp_hit  = bypHit;
    assign byp_data = bypData;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: queue-based reference model compared every cycle plus directed literal checks.
module tb_reg_writeback;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [3:0]  in_wr;
    logic [3:0]  in_data;
    logic        in_overflow;
    logic        rf_hold;
    logic        flush;
    logic        RegWrite;
    logic [3:0]  Wr;
    logic [3:0]  Write_data;
    logic [15:0] busy;
    logic        ovf_sticky;
    logic [7:0]  drop_cnt;
`ifdef WB_BYPASS_EN
    logic [3:0]  byp_addr;
    logic        byp_hit;
    logic [3:0]  byp_data;
`endif

    int compared   = 0;
    int mismatched = 0;

    reg_writeback #(.DEPTH(DEPTH), .DW(4), .AW(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_we(in_we),
        .in_wr(in_wr),
        .in_data(in_data),
        .in_overflow(in_overflow),
        .rf_hold(rf_hold),
        .flush(flush),
        .RegWrite(RegWrite),
        .Wr(Wr),
        .Write_data(Write_data),
        .busy(busy),
        .ovf_sticky(ovf_sticky),
`ifdef WB_BYPASS_EN
        .drop_cnt(drop_cnt),
        .byp_addr(byp_addr),
        .byp_hit(byp_hit),
        .byp_data(byp_data)
`else
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the staged output.
    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
    } ent_t;

    ent_t       mq[$];
    logic       mRW;
    logic [3:0] mWr;
    logic [3:0] mWD;
    logic       mOvf;
    int         mDrop;
    bit         mValid = 0;

    always @(posedge clk) begin
        bit   readyNow;
        ent_t e;
        readyNow = (mq.size() < DEPTH) && (rst === 1'b1) && (flush === 1'b0);
        if (rst === 1'b0) begin
            mq.delete();
            mRW    = 1'b0;
            mWr    = 4'h0;
            mWD    = 4'h0;
            mOvf   = 1'b0;
            mDrop  = 0;
            mValid = 1;
        end else if (flush) begin
            mq.delete();
            mRW = 1'b0;
        end else begin
            if (mq.size() > 0 && !rf_hold) begin
                e   = mq.pop_front();
                mRW = 1'b1;
                mWr = e.a;
                mWD = e.d;
            end else begin
                mRW = 1'b0;
            end
            if (in_valid && readyNow) begin
                if (in_overflow) begin
                    mOvf = 1'b1;
                    if (mDrop < 255) mDrop++;
                end else if (in_we && in_wr != 4'h0) begin
                    e.a = in_wr;
                    e.d = in_data;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] eb;
        if (mValid) begin
            eb = '0;
            foreach (mq[i]) eb[mq[i].a] = 1'b1;
            if (mRW) eb[mWr] = 1'b1;
            eb[0] = 1'b0;
            checkOutput("RegWrite", 32'(RegWrite), 32'(mRW));
            checkOutput("Wr", 32'(Wr), 32'(mWr));
            checkOutput("Write_data", 32'(Write_data), 32'(mWD));
            checkOutput("busy", 32'(busy), 32'(eb));
            checkOutput("in_ready", 32'(in_ready),
                        32'((mq.size() < DEPTH) && (rst === 1'b1) && (flush === 1'b0)));
            checkOutput("ovf_sticky", 32'(ovf_sticky), 32'(mOvf));
            checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrop));
`ifdef WB_BYPASS_EN
            begin
                logic       eh;
                logic [3:0] ed;
                eh = 1'b0;
                ed = 4'h0;
                if (byp_addr != 4'h0) begin
                    if (mRW && mWr == byp_addr) begin
                        eh = 1'b1;
                        ed = mWD;
                    end
                    foreach (mq[i]) begin
                        if (mq[i].a == byp_addr) begin
                            eh = 1'b1;
                            ed = mq[i].d;
                        end
                    end
                end
                checkOutput("byp_hit", 32'(byp_hit), 32'(eh));
                checkOutput("byp_data", 32'(byp_data), 32'(ed));
            end
`endif
        end
    end

    task automatic applyStimulus(input logic v, input logic we, input logic [3:0] wr,
                                 input logic [3:0] d, input logic ovf, input logic hold,
                                 input logic fl);
        in_valid    = v;
        in_we       = we;
        in_wr       = wr;
        in_data     = d;
        in_overflow = ovf;
        rf_hold     = hold;
        flush       = fl;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end by 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
`ifdef WB_BYPASS_EN
        byp_addr = 4'h0;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step(2);
        checkOutput("reset RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        step(1);

        // Single write: visible two edges after accept
        applyStimulus(1, 1, 4'd3, 4'hA, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 RegWrite early", 32'(RegWrite), 32'd0);
        checkOutput("t1 busy3 queued", 32'(busy[3]), 32'd1);
        step(1);
        checkOutput("t1 RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("t1 Wr", 32'(Wr), 32'd3);
        checkOutput("t1 Write_data", 32'(Write_data), 32'hA);
        checkOutput("t1 busy3 staged", 32'(busy[3]), 32'd1);
        step(1);
        checkOutput("t1 RegWrite done", 32'(RegWrite), 32'd0);
        checkOutput("t1 busy clear", 32'(busy), 32'd0);

        // Dropped results
        applyStimulus(1, 1, 4'd0, 4'h5, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, 4'd4, 4'h6, 0, 0, 0);
        step(1);
        applyStimulus(1, 1, 4'd6, 4'h7, 1, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2 ovf_sticky", 32'(ovf_sticky), 32'd1);
        checkOutput("t2 drop_cnt", 32'(drop_cnt), 32'd1);
        step(2);
        checkOutput("t2 no write", 32'(RegWrite), 32'd0);
        checkOutput("t2 busy", 32'(busy), 32'd0);
        applyStimulus(1, 1, 4'd6, 4'h7, 1, 0, 0);
        step(300);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2 drop_cnt sat", 32'(drop_cnt), 32'd255);

        // Hold, fill, then drain in order
        applyStimulus(1, 1, 4'd1, 4'h1, 0, 1, 0);
        step(1);
        applyStimulus(1, 1, 4'd2, 4'h2, 0, 1, 0);
        step(1);
        applyStimulus(1, 1, 4'd3, 4'h3, 0, 1, 0);
        checkOutput("t3 full ready", 32'(in_ready), 32'd0);
        step(1);
        checkOutput("t3 still full", 32'(in_ready), 32'd0);
        checkOutput("t3 held", 32'(RegWrite), 32'd0);
        applyStimulus(1, 1, 4'd3, 4'h3, 0, 0, 0);
        step(1);
        checkOutput("t3 w1 Wr", 32'(Wr), 32'd1);
        checkOutput("t3 w1 data", 32'(Write_data), 32'd1);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 w2 Wr", 32'(Wr), 32'd2);
        checkOutput("t3 w2 RegWrite", 32'(RegWrite), 32'd1);
        step(1);
        checkOutput("t3 w3 Wr", 32'(Wr), 32'd3);
        checkOutput("t3 w3 data", 32'(Write_data), 32'd3);
        step(1);
        checkOutput("t3 idle", 32'(RegWrite), 32'd0);

        // Same-address back-to-back
        applyStimulus(1, 1, 4'd5, 4'h1, 0, 0, 0);
        step(1);
        applyStimulus(1, 1, 4'd5, 4'h2, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4 first data", 32'(Write_data), 32'd1);
        checkOutput("t4 busy5", 32'(busy[5]), 32'd1);
        step(1);
        checkOutput("t4 second data", 32'(Write_data), 32'd2);
        checkOutput("t4 busy5 staged", 32'(busy[5]), 32'd1);
        step(1);
        checkOutput("t4 busy5 clear", 32'(busy[5]), 32'd0);

        // Fill then flush
        applyStimulus(1, 1, 4'd4, 4'h4, 0, 1, 0);
        step(1);
        applyStimulus(1, 1, 4'd6, 4'h6, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t5 busy full", 32'(busy), 32'h0050);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("t5 flush ready", 32'(in_ready), 32'd0);
        step(1);
        applyStimulus(1, 1, 4'd9, 4'h7, 0, 0, 0);
        checkOutput("t5 busy flushed", 32'(busy), 32'd0);
        checkOutput("t5 RegWrite flushed", 32'(RegWrite), 32'd0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step(1);
        checkOutput("t5 post Wr", 32'(Wr), 32'd9);
        checkOutput("t5 post data", 32'(Write_data), 32'd7);
        step(1);

`ifdef WB_BYPASS_EN
        // Forwarding picks the youngest match
        applyStimulus(1, 1, 4'd7, 4'h4, 0, 1, 0);
        step(1);
        applyStimulus(1, 1, 4'd7, 4'h9, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        byp_addr = 4'd7;
        #1;
        checkOutput("t6 hit", 32'(byp_hit), 32'd1);
        checkOutput("t6 data", 32'(byp_data), 32'd9);
        byp_addr = 4'd0;
        #1;
        checkOutput("t6 r0 miss", 32'(byp_hit), 32'd0);
        byp_addr = 4'd3;
        #1;
        checkOutput("t6 other miss", 32'(byp_hit), 32'd0);
        byp_addr = 4'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step(1);
`endif

        // Reset mid-operation
        applyStimulus(1, 1, 4'd2, 4'h5, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        checkOutput("t7 busy", 32'(busy), 32'd0);
        checkOutput("t7 RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("t7 ovf_sticky", 32'(ovf_sticky), 32'd0);
        checkOutput("t7 drop_cnt", 32'(drop_cnt), 32'd0);
        step(1);
        checkOutput("t7 no write", 32'(RegWrite), 32'd0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
